// File: rtl/obi_sram_secondary.sv
// OBI secondary backed by a word-addressed SRAM, with programmable grant wait states
// and a fixed-depth response pipeline.
module obi_sram_secondary #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             handshake;
  logic             in_range;
  logic [29:0]      word_idx;
  logic [AddrW-1:0] mem_idx;
  logic [31:0]      rd_word;
  logic             unused_addr;

  logic [31:0]        mem_q [DEPTH];
  logic [LATENCY-1:0] valid_q;
  logic [31:0]        data_q [LATENCY];

  assign word_idx    = addr_i[31:2];
  assign mem_idx     = word_idx[AddrW-1:0];
  assign in_range    = (word_idx < 30'(DEPTH));
  assign unused_addr = ^addr_i[1:0];

  // Grant is forced low during reset regardless of req_i.
  assign gnt_o     = rst_ni & req_i & (wait_cnt_q == 4'(WAIT_STATES));
  assign handshake = req_i & gnt_o;

  // Counts held-but-ungranted cycles; a dropped req or a grant restarts it.
  always_comb begin
    wait_cnt_d = wait_cnt_q + 4'd1;
    if (!req_i || handshake) begin
      wait_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Memory is intentionally not reset so its contents survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (handshake && we_i && in_range) begin
      for (int n = 0; n < 4; n++) begin
        if (be_i[n]) begin
          mem_q[mem_idx][8*n +: 8] <= wdata_i[8*n +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (handshake && !we_i && in_range) begin
      rd_word = mem_q[mem_idx];
    end
  end

  // Stage data is zero whenever its valid bit is zero, so rdata_o needs no masking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= handshake;
      data_q[0]  <= rd_word;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign rvalid_o = valid_q[LATENCY-1];
  assign rdata_o  = data_q[LATENCY-1];

endmodule

// File: tb/tb_obi_sram_secondary.sv
// Randomized bench for obi_sram_secondary: three configurations run in parallel, each
// checked against a transaction-level memory model and a cycle-stamped response timeline.
module tb_obi_sram_secondary;

  localparam int NDUT = 3;
  localparam int unsigned WS  [NDUT] = '{0, 2, 0};
  localparam int unsigned LAT [NDUT] = '{1, 3, 4};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req    [NDUT];
  logic        we     [NDUT];
  logic [3:0]  be     [NDUT];
  logic [31:0] addr   [NDUT];
  logic [31:0] wdata  [NDUT];
  logic        gnt    [NDUT];
  logic        rvalid [NDUT];
  logic [31:0] rdata  [NDUT];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  logic [31:0] mdl_mem [NDUT][256];
  int          exp_due [NDUT][8];
  logic [31:0] exp_d   [NDUT][8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  obi_sram_secondary #(.DEPTH(256), .WAIT_STATES(WS[0]), .LATENCY(LAT[0])) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
    .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0])
  );
  obi_sram_secondary #(.DEPTH(256), .WAIT_STATES(WS[1]), .LATENCY(LAT[1])) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
    .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1])
  );
  obi_sram_secondary #(.DEPTH(256), .WAIT_STATES(WS[2]), .LATENCY(LAT[2])) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
    .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Response timeline: a slot matches when its due cycle equals the current cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < NDUT; d++) begin
        chk($sformatf("rvalid%0d", d), 32'(rvalid[d]),
            (exp_due[d][cyc % 8] == cyc) ? 32'd1 : 32'd0);
        chk($sformatf("rdata%0d", d), rdata[d],
            (exp_due[d][cyc % 8] == cyc) ? exp_d[d][cyc % 8] : 32'h0);
      end
    end
  end

  task automatic clear_timeline();
    for (int d = 0; d < NDUT; d++)
      for (int s = 0; s < 8; s++) exp_due[d][s] = -1;
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    logic [31:0] lo;
    r  = $urandom_range(0, 9);
    lo = 32'($urandom_range(0, 3));
    if (r == 0) return (32'($urandom_range(256, 4095)) << 2) | lo;
    if (r == 1) return $urandom | 32'h8000_0000;
    if (r < 6)  return (32'($urandom_range(0, 7)) << 2) | lo;
    return (32'($urandom_range(0, 255)) << 2) | lo;
  endfunction

  // Hold req until the (WS+1)th cycle, then apply the transaction to the model.
  task automatic issue(input int d, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] wd);
    logic [31:0] rd;
    logic [29:0] idx;
    int          slot;
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    for (int i = 0; i <= int'(WS[d]); i++) begin
      @(negedge clk);
      chk($sformatf("gnt%0d", d), 32'(gnt[d]), (i == int'(WS[d])) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    idx = a[31:2];
    rd  = '0;
    if (idx < 30'd256) begin
      if (!w) rd = mdl_mem[d][idx[7:0]];
      else
        for (int n = 0; n < 4; n++)
          if (b[n]) mdl_mem[d][idx[7:0]][8*n +: 8] = wd[8*n +: 8];
    end
    slot = (cyc + int'(LAT[d]) - 1) % 8;
    exp_due[d][slot] = cyc + int'(LAT[d]) - 1;
    exp_d[d][slot]   = rd;
    req[d] = 1'b0;
  endtask

  task automatic idle(input int d, input int n);
    req[d] = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk($sformatf("idle_gnt%0d", d), 32'(gnt[d]), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // Request for fewer cycles than the wait count, then drop it.
  task automatic partial(input int d, input int m);
    req[d] = 1'b1; we[d] = 1'b0; addr[d] = rnd_addr();
    repeat (m) begin
      @(negedge clk);
      chk($sformatf("part_gnt%0d", d), 32'(gnt[d]), 32'd0);
      @(posedge clk); #1;
    end
    idle(d, 1);
  endtask

  task automatic drive(input int d);
    issue(d, 1'b1, 32'h10, 4'hF, 32'h1234_5678);
    issue(d, 1'b0, 32'h10, 4'hF, 32'h0);
    issue(d, 1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF);
    issue(d, 1'b1, 32'h20, 4'h5, 32'h00AA_00BB);
    issue(d, 1'b0, 32'h20, 4'h0, 32'h0);
    issue(d, 1'b1, 32'h400, 4'hF, 32'hCAFE_F00D);
    issue(d, 1'b0, 32'h400, 4'hF, 32'h0);
    if (WS[d] > 0) begin
      partial(d, 1);
      issue(d, 1'b0, 32'h10, 4'hF, 32'h0);
    end
    for (int i = 0; i < 256; i++) issue(d, 1'b1, 32'(i) << 2, 4'hF, $urandom);
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 3) == 0) idle(d, int'($urandom_range(1, 3)));
      if (WS[d] > 0 && $urandom_range(0, 9) == 0) partial(d, int'($urandom_range(1, WS[d])));
      issue(d, 1'($urandom_range(0, 1)), rnd_addr(), 4'($urandom), $urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear_timeline();
    for (int d = 0; d < NDUT; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; be[d] = '0; addr[d] = '0; wdata[d] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) req[d] = 1'b1;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("rst_gnt%0d", d), 32'(gnt[d]), 32'd0);
      chk($sformatf("rst_rvalid%0d", d), 32'(rvalid[d]), 32'd0);
      chk($sformatf("rst_rdata%0d", d), rdata[d], 32'h0);
      req[d] = 1'b0;
    end
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    fork
      drive(0);
      drive(1);
      drive(2);
    join
    idle(2, 6);

    // Reset with three reads in flight on the deepest pipeline.
    issue(2, 1'b0, 32'h0, 4'hF, 32'h0);
    issue(2, 1'b0, 32'h4, 4'hF, 32'h0);
    issue(2, 1'b0, 32'h8, 4'hF, 32'h0);
    @(posedge clk); #1;
    chk("pre_rst_rvalid", 32'(rvalid[2]), 32'd1);
    req[2] = 1'b1;
    rst_n  = 1'b0;
    #1;
    clear_timeline();
    chk("mid_rst_rvalid", 32'(rvalid[2]), 32'd0);
    chk("mid_rst_rdata", rdata[2], 32'h0);
    chk("mid_rst_gnt", 32'(gnt[2]), 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    req[2] = 1'b0;
    idle(2, 8);
    issue(2, 1'b0, 32'h0, 4'hF, 32'h0);
    issue(2, 1'b0, 32'h4, 4'hF, 32'h0);
    issue(2, 1'b0, 32'h8, 4'hF, 32'h0);
    issue(0, 1'b0, 32'h20, 4'hF, 32'h0);
    issue(1, 1'b0, 32'h24, 4'hF, 32'h0);
    idle(2, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
